// File: rtl/example_producer.sv
// example_producer: F2C traffic generator filling a ring of chunks with a counted word sequence and checksum.
module example_producer #(
  parameter int PTR_BITS = 3,
  parameter int OFF_BITS = 4
) (
  input  logic                sysClk,
  input  logic                sysRst_n,
  input  logic                csReset,
  input  logic [31:0]         countInit,
  input  logic [PTR_BITS-1:0] rdPtr,
  output logic [PTR_BITS-1:0] wrPtr,
  output logic                wrEnable,
  output logic [7:0]          wrByteMask,
  output logic [OFF_BITS-1:0] wrOffset,
  output logic [63:0]         wrData,
  output logic [63:0]         csData,
  output logic                csValid,
  output logic                busy
);
  typedef enum logic [1:0] {IDLE, FILL, COMMIT, DONE} state_t;
  state_t              state_q, state_d;
  logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d, ptr_inc;
  logic [OFF_BITS-1:0] off_q, off_d, wr_offset_q, wr_offset_d;
  logic [31:0]         n_q, n_d, rem_q, rem_d;
  logic [63:0]         wr_data_q, wr_data_d, cs_q, cs_d, word;
  logic                wr_en_q, wr_en_d, cs_valid_q, cs_valid_d, busy_q, busy_d;
  logic [7:0]          mask_q, mask_d;
  logic                full, issue, last;
  assign ptr_inc = wr_ptr_q + 1'b1;
  assign full    = ptr_inc == rdPtr;
  // A full ring only blocks the start of a chunk; a started chunk always finishes.
  assign issue   = state_q == FILL && !(off_q == '0 && full);
  assign last    = off_q == '1;
  assign word    = {~n_q, n_q};
  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      off_q       <= '0;
      wr_offset_q <= '0;
      n_q         <= '0;
      rem_q       <= '0;
      wr_data_q   <= '0;
      cs_q        <= '0;
      wr_en_q     <= 1'b0;
      mask_q      <= '0;
      cs_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      off_q       <= off_d;
      wr_offset_q <= wr_offset_d;
      n_q         <= n_d;
      rem_q       <= rem_d;
      wr_data_q   <= wr_data_d;
      cs_q        <= cs_d;
      wr_en_q     <= wr_en_d;
      mask_q      <= mask_d;
      cs_valid_q  <= cs_valid_d;
      busy_q      <= busy_d;
    end
  end
  always_comb begin
    state_d = state_q;
    if (csReset) state_d = countInit != '0 ? FILL : DONE;
    else if (issue && last) state_d = COMMIT;
    else if (state_q == COMMIT) state_d = rem_q == 32'd1 ? DONE : FILL;
  end
  // wrPtr is kept across csReset so the host's view of the ring stays valid.
  always_comb begin
    wr_en_d     = issue && !csReset;
    mask_d      = wr_en_d ? 8'hFF : 8'h00;
    wr_data_d   = wr_en_d ? word : wr_data_q;
    off_d       = csReset ? '0 : issue ? off_q + 1'b1 : off_q;
    wr_offset_d = csReset || state_q == COMMIT ? '0 : issue ? off_q : wr_offset_q;
    n_d         = csReset ? '0 : issue ? n_q + 32'd1 : n_q;
    cs_d        = csReset ? '0 : issue ? cs_q + word : cs_q;
    rem_d       = csReset ? countInit : state_q == COMMIT ? rem_q - 32'd1 : rem_q;
    wr_ptr_d    = !csReset && state_q == COMMIT ? ptr_inc : wr_ptr_q;
    cs_valid_d  = state_d == DONE;
    busy_d      = state_d == FILL || state_d == COMMIT;
  end
  assign wrPtr      = wr_ptr_q;
  assign wrEnable   = wr_en_q;
  assign wrByteMask = mask_q;
  assign wrOffset   = wr_offset_q;
  assign wrData     = wr_data_q;
  assign csData     = cs_q;
  assign csValid    = cs_valid_q;
  assign busy       = busy_q;
endmodule

// File: doc/example_producer.md
Name: example_producer

Overview:
- FPGA->CPU (F2C) traffic generator. It is the counterpart of the C2F example consumer.
- Fills a ring of F2C chunks in a byte-enabled RAM with a deterministic word sequence.
- Publishes each completed chunk by advancing wrPtr, and respects the host's rdPtr so unread chunks are never overwritten.
- Accumulates a 64-bit checksum and raises csValid when the requested number of chunks has been produced.

Parameters:
- PTR_BITS, 3, chunk pointer width; the ring holds 2**PTR_BITS chunks.
- OFF_BITS, 4, word-offset width; a chunk is 2**OFF_BITS 64-bit words (default 128 bytes).

Ports:
- sysClk  in  1  system clock; all logic on the rising edge.
- sysRst_n  in  1  asynchronous, active-low reset.
- csReset  in  1  synchronous start/restart pulse.
- countInit  in  32  number of chunks to produce; sampled on csReset.
- rdPtr  in  PTR_BITS  host read pointer: index of the next chunk the host will consume.
- wrPtr  out  PTR_BITS  committed write pointer: index of the chunk being filled / next to publish.
- wrEnable  out  1  RAM write strobe.
- wrByteMask  out  8  RAM byte enables; all-ones whenever wrEnable=1, else 0.
- wrOffset  out  OFF_BITS  word offset within chunk wrPtr.
- wrData  out  64  RAM write data.
- csData  out  64  running checksum.
- csValid  out  1  checksum final / run complete.
- busy  out  1  high in FILL or COMMIT.

Behaviour:
- All outputs are registered.
- Reset (sysRst_n=0, asynchronous):
  - state=IDLE;
  - wrPtr=0, wrOffset=0, wrEnable=0, wrByteMask=0, wrData=0;
  - csData=0, csValid=0, busy=0;
  - internal word counter n=0, remaining=0.
- States: IDLE, FILL, COMMIT, DONE.
- csReset=1, from any state, has priority over all other transitions:
  - remaining<=countInit, n<=0, csData<=0, csValid<=0, wrOffset<=0, wrEnable<=0;
  - next state is FILL if countInit!=0, else DONE (csValid<=1, csData=0);
  - wrPtr is NOT cleared, so ring continuity with the host is preserved;
  - a partially filled chunk is abandoned and is overwritten from offset 0.
- Full condition: (wrPtr+1) mod 2**PTR_BITS == rdPtr. Usable capacity is 2**PTR_BITS-1 chunks.
- FILL:
  - Full is evaluated only when wrOffset==0 (chunk start). If full, wrEnable<=0 and the block stays in FILL (stall).
  - Once a chunk is started, it completes regardless of rdPtr.
  - Each non-stalled cycle presents one write on the next cycle:
    - wrEnable=1, wrByteMask=8'hFF;
    - wrData={~n[31:0], n[31:0]};
    - wrOffset increments;
    - n<=n+1 (32-bit wrap);
    - csData<=csData+wrData (64-bit modulo-2**64 add of the word written).
  - After the word at wrOffset==2**OFF_BITS-1 is issued, go to COMMIT.
- COMMIT (one cycle):
  - wrEnable=0, wrPtr<=wrPtr+1 (wraps mod 2**PTR_BITS), remaining<=remaining-1;
  - the pointer advances strictly after the chunk's last write, so the host never sees a pointer ahead of the data;
  - next state is DONE if remaining==1, else FILL with wrOffset=0.
- DONE: csValid=1 and csData held until the next csReset or reset.
- IDLE: waits for csReset.
- Throughput: 2**OFF_BITS+1 cycles per chunk when not stalled.
- rdPtr changes are honoured in the cycle they are seen. rdPtr==wrPtr means empty, i.e. no stall.
- Reset asserted mid-chunk forces the reset values immediately, including wrEnable=0.

Test Plan:
- Single chunk: reset, rdPtr=0, csReset with countInit=1.
  - Expect 16 writes at offsets 0..15 with wrData 0xFFFFFFFF_00000000 ... 0xFFFFFFF0_0000000F, byte mask FF.
  - Then wrPtr 0->1 one cycle after the last write.
  - Then csValid=1 with csData=0xFFFFFF78_00000078. Total 17 cycles busy.
- Back-pressure: rdPtr held at 0, countInit=10.
  - wrPtr reaches 7 and the block stalls with wrEnable=0 and busy=1.
  - Set rdPtr=3: the block resumes, produces 3 more chunks and wrPtr ends at 2 (wrap). csValid=1 after 10 commits.
  - Check the word counter is continuous: the first word of chunk 8 is {~32'd112, 32'd112}.
- Zero count: csReset with countInit=0 -> DONE next cycle, csValid=1, csData=0, no writes, wrPtr unchanged.
- Restart mid-chunk: countInit=2, pulse csReset again at wrOffset=5 of the first chunk.
  - Writes restart at offset 0 with n=0 into the same wrPtr.
  - csData at completion equals the clean two-chunk value.
- Async reset mid-run: drop sysRst_n between clock edges during FILL.
  - All outputs go to their reset values without waiting for a clock edge.
  - wrPtr=0; no writes occur until the next csReset.
- Ring continuity: run countInit=3 twice with rdPtr kept equal to wrPtr.
  - wrPtr goes 0->3, then 3->6.
  - The second run's first word is {~32'd0, 32'd0}.
